comparator_serial_param: RTL and testbench
==========================================

Name: comparator_serial_param

Overview:
- Parametrised, digit-serial, MSB-first magnitude comparator. Successor to the team's fixed 8-bit combinational eq/gt/lt comparator.
- Compares two WIDTH-bit operands, DIGIT bits per cycle, with a valid/ready handshake on both sides and a selectable signed/unsigned mode.
- Sits in datapaths where a wide compare cannot close timing in one cycle, or where area matters more than throughput.

Parameters:
- WIDTH, 32, operand width in bits.
- DIGIT, 8, bits compared per cycle. WIDTH % DIGIT must be 0; any other value is an elaboration error. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare; sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- eq  out  1  A == B.
- gt  out  1  A > B.
- lt  out  1  A < B.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state IDLE; out_valid=0, eq=gt=lt=0; operand registers cleared. in_ready=1 from the first cycle after rst deasserts. in_valid is ignored while rst=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T: latch a, b and signed_mode; set idx=NDIG-1; go to RUN.
  - RUN: in_ready=0. Each cycle compare digit idx of A vs B.
    - If unequal: record gt/lt from that digit; stop examining lower digits.
    - If idx==0 or (EARLY_EXIT_EN and a difference was found): go to DONE. Otherwise idx--.
  - DONE: out_valid=1; eq/gt/lt held stable until out_ready. On out_valid&&out_ready go to IDLE.
- Signed handling: when signed_mode=1, invert the MSB of both operands at capture, then run the unsigned compare.
- Results:
  - eq=1 only if no digit differed.
  - When out_valid=1, exactly one of eq/gt/lt is high.
  - All three are 0 whenever out_valid=0.
- Latency, accept at edge T:
  - Without EARLY_EXIT_EN, out_valid rises in cycle T+NDIG+1, fixed.
  - With EARLY_EXIT_EN, out_valid rises in cycle T+k+1, where k is the 1-based position (from MSB) of the first differing digit; k=NDIG if equal.
- Throughput: no same-cycle turnaround. The DONE handshake returns to IDLE and in_ready rises the following cycle.
- Boundaries:
  - NDIG=1: RUN lasts one cycle.
  - in_valid held during RUN/DONE is not consumed.
  - Operand inputs may change after acceptance without effect.
  - Reset in RUN or DONE aborts the compare; no result is emitted and the pending result is discarded.
  - idx never wraps below 0.

Optional Feature:
- Macro: COMPARATOR_SERIAL_EARLY_EXIT_EN.
- Defined: RUN ends on the first differing digit, giving data-dependent latency.
- Undefined: always NDIG RUN cycles, giving constant latency for timing-predictable pipelines. Results are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - state enum typedef (IDLE, RUN, DONE);
  - 2-bit result encoding constants (RES_EQ, RES_GT, RES_LT);
  - helper function computing NDIG and index width.
- One natural sub-module: cmp_digit, a combinational DIGIT-bit compare producing d_eq/d_gt. It is instantiated once and muxed by idx.

Test Plan (WIDTH=32, DIGIT=8):
- a=b=0x12345678, unsigned → eq=1, gt=lt=0; out_valid at T+5 in both builds.
- a=0x80000000, b=0x7FFFFFFF, unsigned → gt=1; out_valid at T+2 with EARLY_EXIT_EN, T+5 without.
- Same operands with signed_mode=1 → lt=1; same latency as previous case.
- a=0x00000001, b=0x00000002 → lt=1 at T+5 in both builds (difference only in the last digit).
- Backpressure: out_ready=0 for 3 cycles after out_valid → out_valid and gt held, in_ready=0, a concurrent in_valid not accepted. out_ready=1 → in_ready=1 next cycle.
- rst pulsed one cycle at T+2 mid-RUN → out_valid never asserts for that op; in_ready=1 the cycle after rst drops; next op a=5, b=3 → gt=1.

Source files
------------

// File: rtl/comparator_serial_param_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Provides the FSM state enum, the result encoding and digit-count helpers.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [1:0] res_t;

    localparam res_t RES_EQ = 2'd0;
    localparam res_t RES_GT = 2'd1;
    localparam res_t RES_LT = 2'd2;

    function automatic int ndig_of(int w, int d);
        return w / d;
    endfunction

    function automatic int idx_w_of(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparator_serial_param_if.sv
// Operand/result handshake bundle for comparator_serial_param.
// master: producer/consumer side; slave: the comparator.
interface comparator_serial_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, eq, gt, lt
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, eq, gt, lt
    );

endinterface

// File: rtl/comparator_serial_param_digit.sv
// Combinational compare of one DIGIT-bit slice.
// Ports: a, b (digit operands); d_eq (a==b), d_gt (a>b, unsigned).
module cmp_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             d_eq,
    output logic             d_gt
);

    assign d_eq = (a == b);
    assign d_gt = (a > b);

endmodule

// File: rtl/comparator_serial_param.sv
// Digit-serial MSB-first eq/gt/lt comparator, signed or unsigned.
// Ports: clk, rst (sync, active-high), bus (slave: operands in, result out).
// Macro COMPARATOR_SERIAL_EARLY_EXIT_EN: stop on first differing digit.
module comparator_serial_param
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    comparator_serial_param_if.slave    bus
);

    localparam int NDIG = ndig_of(WIDTH, DIGIT);
    localparam int IW   = idx_w_of(NDIG);
    localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             found;
    res_t             res;

    logic [DIGIT-1:0] a_digs [NDIG];
    logic [DIGIT-1:0] b_digs [NDIG];

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        assign a_digs[i] = a_q[i*DIGIT +: DIGIT];
        assign b_digs[i] = b_q[i*DIGIT +: DIGIT];
    end

    logic d_eq;
    logic d_gt;

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_digs[idx]),
        .b    (b_digs[idx]),
        .d_eq (d_eq),
        .d_gt (d_gt)
    );

    // Only the first (most significant) differing digit decides.
    logic hit;
    logic last;
    res_t res_n;

    always_comb begin
        hit   = !found && !d_eq;
        res_n = res;
        if (hit) res_n = d_gt ? RES_GT : RES_LT;
        last  = (idx == '0) || (EARLY && hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            idx           <= '0;
            found         <= 1'b0;
            res           <= RES_EQ;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.eq        <= 1'b0;
            bus.gt        <= 1'b0;
            bus.lt        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        // Flipping the MSBs maps two's complement
                        // order onto unsigned order.
                        a_q <= {bus.a[WIDTH-1] ^ bus.signed_mode,
                                bus.a[WIDTH-2:0]};
                        b_q <= {bus.b[WIDTH-1] ^ bus.signed_mode,
                                bus.b[WIDTH-2:0]};
                        idx          <= IDX_TOP;
                        found        <= 1'b0;
                        res          <= RES_EQ;
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    res <= res_n;
                    if (hit) found <= 1'b1;
                    if (last) begin
                        bus.out_valid <= 1'b1;
                        bus.eq        <= (res_n == RES_EQ);
                        bus.gt        <= (res_n == RES_GT);
                        bus.lt        <= (res_n == RES_LT);
                        state         <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.eq        <= 1'b0;
                        bus.gt        <= 1'b0;
                        bus.lt        <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial_param.sv
// Self-checking bench for comparator_serial_param (WIDTH=32, DIGIT=8).
// Honours COMPARATOR_SERIAL_EARLY_EXIT_EN for expected latency.
module tb_comparator_serial_param;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [2:0] res;
        int         due;
    } exp_t;

    exp_t q[$];

    comparator_serial_param_if #(.WIDTH(W)) bus ();

    comparator_serial_param #(.WIDTH(W), .DIGIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    // {eq,gt,lt}
    function automatic logic [2:0] model(logic [W-1:0] x,
                                         logic [W-1:0] y,
                                         logic s);
        if (x == y) return 3'b100;
        if (s) return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
        return (x > y) ? 3'b010 : 3'b001;
    endfunction

    function automatic int exp_lat(logic [W-1:0] x, logic [W-1:0] y);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        for (int k = 1; k <= N; k++)
            if (x[(N-k)*8 +: 8] != y[(N-k)*8 +: 8]) return k;
`endif
        return N;
    endfunction

    task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic s);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a           = x;
        bus.b           = y;
        bus.signed_mode = s;
        for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t     = cyc;
        e.res = model(x, y, s);
        e.due = t + exp_lat(x, y) + 1;
        q.push_back(e);
        #1;
        bus.in_valid    = 1'b0;
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.signed_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("result_timeout", 64'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard when a result appears.
    initial begin : mon
        logic       prev_ov;
        logic [2:0] held;
        exp_t       e;
        prev_ov = 1'b0;
        held    = 3'b000;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else if (bus.out_valid && !prev_ov) begin
                held = {bus.eq, bus.gt, bus.lt};
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", 64'(held), 64'(e.res));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
                prev_ov = 1'b1;
            end else if (bus.out_valid) begin
                chk("hold", 64'({bus.eq, bus.gt, bus.lt}), 64'(held));
            end else begin
                chk("idle_zero", 64'({bus.eq, bus.gt, bus.lt}), 0);
                prev_ov = 1'b0;
            end
        end
    end

    initial begin : drv
        logic [W-1:0] x;
        logic [W-1:0] y;
        bus.in_valid    = 1'b1;
        bus.a           = 32'h1;
        bus.b           = 32'h2;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b1;
        rst             = 1'b1;
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 1);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_res", 64'({bus.eq, bus.gt, bus.lt}), 0);

        send(32'h12345678, 32'h12345678, 1'b0);
        drain();
        send(32'h80000000, 32'h7FFFFFFF, 1'b0);
        drain();
        send(32'h80000000, 32'h7FFFFFFF, 1'b1);
        drain();
        send(32'h00000001, 32'h00000002, 1'b0);
        drain();
        send(32'hFFFFFFFF, 32'h00000000, 1'b1);
        drain();
        send(32'hFFFFFFFF, 32'h00000000, 1'b0);
        drain();
        send(32'h00FF0000, 32'h00FE0000, 1'b1);
        drain();

        // Backpressure
        bus.out_ready = 1'b0;
        send(32'h80000000, 32'h7FFFFFFF, 1'b0);
        for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            chk("bp_valid", 64'(bus.out_valid), 1);
            chk("bp_gt", 64'(bus.gt), 1);
            chk("bp_in_ready", 64'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 64'(bus.out_valid), 0);
        chk("bp_release_rdy", 64'(bus.in_ready), 1);
        chk("bp_queue", 64'(q.size()), 0);

        // Reset mid-RUN
        send(32'h00000001, 32'h00000002, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(bus.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_out", 64'(bus.out_valid), 0);
            @(negedge clk);
        end
        send(32'd5, 32'd3, 1'b0);
        drain();

        // Random mix
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            if (i % 3 == 0) y = x;
            else if (i % 3 == 1) y = x ^ (32'h1 << $urandom_range(0, 31));
            else y = $urandom;
            send(x, y, 1'($urandom_range(0, 1)));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
